// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants: byte width and default FIFO sizing.
package uart_rx_fifo_pkg;

   localparam int unsigned UART_DATA_W   = 8;
   localparam int unsigned FIFO_DEPTH    = 16;
   localparam int unsigned FIFO_AF_LEVEL = 12;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W register array, one synchronous write port and
// one asynchronous read port.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from the array)
module uart_rx_fifo_mem
   import uart_rx_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = UART_DATA_W,
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is deliberately not reset; empty/valid tracking makes it don't-care.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : uart_rx_fifo_mem

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures rx_data on each rising edge of rx_done into a
// FIFO and presents it on a first-word-fall-through valid/ready port.
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   rx_data      in   byte from the receiver
//   rx_done      in   receiver byte-complete strobe (rising edge writes once)
//   out_data     out  head-of-FIFO byte (0 when empty)
//   out_valid    out  FIFO non-empty
//   out_ready    in   consumer accepts out_data this cycle
//   count        out  occupancy 0..DEPTH
//   almost_full  out  count >= AF_LEVEL
//   overrun      out  sticky: a byte was dropped while full
//   clr_overrun  in   clears overrun (a simultaneous drop wins)
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = UART_DATA_W,
   parameter int unsigned DEPTH    = FIFO_DEPTH,
   parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_done,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AW:0]       count,
   output logic              almost_full,
   output logic              overrun,
   input  logic              clr_overrun
);

   logic              rx_done_d;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [AW:0]       count_nxt;
   logic              empty;
   logic              full;
   logic              wr_req;
   logic              wr_fire;
   logic              rd_fire;
   logic              drop;
   logic [DATA_W-1:0] head_data;

   // Extra wrap bit distinguishes full from empty when the addresses match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_req  = rx_done & ~rx_done_d;
   assign rd_fire = out_valid & out_ready;
   // A read in the same cycle frees a slot, so a write to a full FIFO still lands.
   assign wr_fire = wr_req & (~full | rd_fire);
   assign drop    = wr_req & full & ~rd_fire;

   assign out_valid = ~empty;
   assign out_data  = out_valid ? head_data : '0;

   // Occupancy update.
   always_comb begin
      count_nxt = count;
      unique case ({wr_fire, rd_fire})
         2'b10:   count_nxt = count + (AW+1)'(1);
         2'b01:   count_nxt = count - (AW+1)'(1);
         default: count_nxt = count;
      endcase
   end

   // Edge detector, pointers, count and flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_done_d   <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         rx_done_d   <= rx_done;
         count       <= count_nxt;
         almost_full <= (count_nxt >= (AW+1)'(AF_LEVEL));
         if (wr_fire) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   uart_rx_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (rx_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (head_data)
   );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned AF_LEVEL = 12;
   localparam int unsigned AW       = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] rx_data;
   logic              rx_done;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [AW:0]       count;
   logic              almost_full;
   logic              overrun;
   logic              clr_overrun;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DATA_W-1:0] q[$];
   logic              m_ovr;
   logic              m_prev;

   always #5 clk = ~clk;

   uart_rx_fifo dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .count       (count),
      .almost_full (almost_full),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [DATA_W-1:0] head;
      head = (q.size() != 0) ? q[0] : '0;
      check({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
      check({tag, ".count"}, 32'(count), 32'(q.size()));
      check({tag, ".af"}, 32'(almost_full), 32'(q.size() >= AF_LEVEL));
      check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
      check({tag, ".data"}, 32'(out_data), 32'(head));
   endtask

   // One clock: drive inputs, advance the model from pre-edge state, check after edge.
   task automatic step(input logic done, input logic [DATA_W-1:0] d,
                       input logic rdy, input logic clr, input string tag);
      logic req, rd, was_full;
      rx_done     = done;
      rx_data     = d;
      out_ready   = rdy;
      clr_overrun = clr;
      req      = done & ~m_prev;
      rd       = (q.size() != 0) & rdy;
      was_full = (q.size() == DEPTH);
      if (rd) void'(q.pop_front());
      if (req && (!was_full || rd)) q.push_back(d);
      if (req && was_full && !rd) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      m_prev = done;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic pulse(input logic [DATA_W-1:0] d, input logic rdy, input string tag);
      step(1'b1, d, rdy, 1'b0, tag);
      step(1'b0, 8'h00, 1'b0, 1'b0, tag);
   endtask

   initial begin
      reset = 1'b0;
      rx_data = '0; rx_done = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
      m_ovr = 1'b0; m_prev = 1'b0;
      #2;
      check_all("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      // Single byte in and out
      step(1'b1, 8'hA5, 1'b0, 1'b0, "single_wr");
      check("single_A5", 32'(out_data), 32'h0000_00A5);
      step(1'b0, 8'h00, 1'b1, 1'b0, "single_rd");

      // Fill to DEPTH with no reader
      for (int i = 0; i < DEPTH; i++) pulse(8'(i), 1'b0, "fill");
      check("fill_count", 32'(count), 32'(DEPTH));

      // Overrun while full, then set-wins-over-clear, then clear
      pulse(8'hFF, 1'b0, "ovr_drop");
      check("ovr_head", 32'(out_data), 32'h0);
      step(1'b1, 8'hEE, 1'b0, 1'b1, "ovr_setwins");
      step(1'b0, 8'h00, 1'b0, 1'b1, "ovr_clr");

      // Full with simultaneous read: write accepted
      step(1'b1, 8'h77, 1'b1, 1'b0, "full_rdwr");
      step(1'b0, 8'h00, 1'b0, 1'b0, "full_idle");
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");

      // Held strobe writes once
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "held");
      step(1'b0, 8'h00, 1'b0, 1'b0, "held_rel");

      // Write/read pairs wrap the pointers
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 8'($urandom), 1'b0, 1'b0, "wrap_wr");
         step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_rd");
      end

      // Random traffic
      for (int i = 0; i < 300; i++)
         step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 15) == 0), "rand");

      // Async reset mid-operation with count = 7
      while (q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_drain");
      for (int i = 0; i < 7; i++) pulse(8'($urandom), 1'b0, "pre_rst");
      check("pre_rst_count", 32'(count), 32'd7);
      #3;
      reset = 1'b0;
      #1;
      q.delete(); m_ovr = 1'b0; m_prev = 1'b0;
      check_all("async_rst");
      @(posedge clk); #1;
      check_all("rst_hold");
      reset = 1'b1;
      pulse(8'h3C, 1'b0, "post_rst");
      check("post_rst_data", 32'(out_data), 32'h0000_003C);
      step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_uart_rx_fifo
